// File: rtl/entity_update_scheduler.sv
// entity_update_scheduler
//   Per-frame walker over the entity slots. On a frame trigger each slot is
//   visited in index order. An active slot gets a one-cycle update strobe, and
//   the walker then waits a bounded time for that slot's done handshake. When
//   the slot answers in time, its new tile is compared against the sword tile
//   and the player tile. A sword hit produces a kill pulse and masks any player
//   hit from that slot. One player-hit verdict is published per frame.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   frame_trigger    1-cycle pulse that starts a frame walk
//   slot_active      per-slot live flag
//   slot_done        per-slot done level; only the current slot is sampled, and only in WAIT
//   slot_pos         per-slot tile xxxx_yyyy, slot i at [8i+7:8i]
//   player_pos       player tile xxxx_yyyy
//   sword_position   sword tile xxxx_yyyy (8'hFF = none)
//   sword_visible    4'b0001 = sword shown
//   slot_update_en   one-hot update strobe (ISSUE cycle)
//   slot_kill        one-hot kill pulse, registered from the CHECK cycle
//   player_hit       verdict of the last completed frame
//   frame_done       1-cycle pulse while in DONE
//   busy             high outside IDLE
//   timeout_flags    sticky per-slot timeout record
//   frame_overrun    sticky: trigger seen while busy
//
// state | meaning
// IDLE  | waiting for frame_trigger
// SCAN  | look at slot idx; skip it in one cycle if inactive
// ISSUE | strobe slot idx, load the done timer
// WAIT  | wait for slot_done[idx] or timer expiry
// CHECK | compare slot tile against sword / player tiles
// DONE  | publish player_hit, pulse frame_done

module entity_update_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_trigger,
    input  logic [NUM_SLOTS-1:0]   slot_active,
    input  logic [NUM_SLOTS-1:0]   slot_done,
    input  logic [8*NUM_SLOTS-1:0] slot_pos,
    input  logic [7:0]             player_pos,
    input  logic [7:0]             sword_position,
    input  logic [3:0]             sword_visible,
    output logic [NUM_SLOTS-1:0]   slot_update_en,
    output logic [NUM_SLOTS-1:0]   slot_kill,
    output logic                   player_hit,
    output logic                   frame_done,
    output logic                   busy,
    output logic [NUM_SLOTS-1:0]   timeout_flags,
    output logic                   frame_overrun
);

    localparam int             IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    // Down-counter loaded so that expiry lands on the TIMEOUT-th WAIT cycle.
    localparam logic [7:0]     TMO_LOAD = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [7:0]           timer;
    logic                 hit_acc;

    logic [NUM_SLOTS-1:0] idx_onehot;
    logic                 active_cur;
    logic                 done_cur;
    logic [7:0]           cur_pos;
    logic                 sword_match;
    logic                 player_match;
    logic                 is_last;

    always_comb begin
        idx_onehot = NUM_SLOTS'(1) << idx;
        active_cur = |(slot_active & idx_onehot);
        done_cur   = |(slot_done & idx_onehot);
        cur_pos    = 8'hFF;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_pos = slot_pos[8*i +: 8];
            end
        end
        // A tile of 8'hFF never matches anything, so "no sword" and unplaced slots are inert.
        sword_match  = (sword_visible == 4'b0001) && (sword_position != 8'hFF) &&
                       (cur_pos == sword_position);
        player_match = (player_pos != 8'hFF) && (cur_pos == player_pos);
        is_last      = (idx == LAST_IDX);
    end

    assign slot_update_en = (state == S_ISSUE) ? idx_onehot : '0;
    assign frame_done     = (state == S_DONE);
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            timer         <= '0;
            hit_acc       <= 1'b0;
            slot_kill     <= '0;
            player_hit    <= 1'b0;
            timeout_flags <= '0;
            frame_overrun <= 1'b0;
        end else begin
            slot_kill <= '0;
            // A trigger while busy, DONE included, is dropped and only recorded.
            if (frame_trigger && (state != S_IDLE)) begin
                frame_overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (frame_trigger) begin
                        state   <= S_SCAN;
                        idx     <= '0;
                        hit_acc <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (active_cur) begin
                        state <= S_ISSUE;
                    end else if (is_last) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_ISSUE: begin
                    timer <= TMO_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_cur) begin
                        state <= S_CHECK;
                    end else if (timer == '0) begin
                        // An abandoned slot is never position-checked.
                        timeout_flags <= timeout_flags | idx_onehot;
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_SCAN;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (sword_match) begin
                        slot_kill <= idx_onehot;
                    end else if (player_match) begin
                        hit_acc <= 1'b1;
                    end
                    if (is_last) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_DONE: begin
                    player_hit <= hit_acc;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_entity_update_scheduler.sv
// tb_entity_update_scheduler
//   Table vectors with hand-derived expectations, hand-written reset/overrun
//   sequences, then random frames checked against a slot-by-slot cost model.
//   A responder raises slot_done a chosen number of WAIT cycles after each
//   strobe and drives random levels on slot_done whenever no handshake is pending.

module tb_entity_update_scheduler;

    localparam int NS  = 4;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_trigger;
    logic [3:0]  slot_active;
    logic [3:0]  slot_done;
    logic [31:0] slot_pos;
    logic [7:0]  player_pos;
    logic [7:0]  sword_position;
    logic [3:0]  sword_visible;
    logic [3:0]  slot_update_en;
    logic [3:0]  slot_kill;
    logic        player_hit;
    logic        frame_done;
    logic        busy;
    logic [3:0]  timeout_flags;
    logic        frame_overrun;

    always #5 clk = ~clk;

    entity_update_scheduler #(.NUM_SLOTS(NS), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_trigger  (frame_trigger),
        .slot_active    (slot_active),
        .slot_done      (slot_done),
        .slot_pos       (slot_pos),
        .player_pos     (player_pos),
        .sword_position (sword_position),
        .sword_visible  (sword_visible),
        .slot_update_en (slot_update_en),
        .slot_kill      (slot_kill),
        .player_hit     (player_hit),
        .frame_done     (frame_done),
        .busy           (busy),
        .timeout_flags  (timeout_flags),
        .frame_overrun  (frame_overrun)
    );

    typedef struct {
        logic [3:0]      active;
        logic [3:0][7:0] lat;      // WAIT cycle index at which done rises; >= TMO means never
        logic [3:0][7:0] pos;
        logic [7:0]      player;
        logic [7:0]      sword;
        logic [3:0]      vis;
        int              exp_cyc;  // cycle of frame_done, trigger cycle = 0
        logic [3:0]      exp_kill;
        logic            exp_hit;
        logic [3:0]      exp_tmo;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc;
    vec_t       cur;
    logic [3:0] waiting;
    int         ctr [4];
    logic [3:0] exp_tmo_acc;
    logic       exp_ovr;
    logic       prev_hit;
    logic [7:0] tiles [4];
    vec_t       tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (waiting[i]) begin
                slot_done[i] = (ctr[i] == int'(cur.lat[i]));
                if (ctr[i] >= int'(cur.lat[i]) || ctr[i] >= TMO - 1) waiting[i] = 1'b0;
                ctr[i]++;
            end else begin
                slot_done[i] = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (slot_update_en[i]) begin
                waiting[i] = 1'b1;
                ctr[i]     = 0;
            end
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.active = 4'b0000;
        v.lat    = '0;
        v.pos    = {4{8'hFF}};
        v.player = 8'h77;
        v.sword  = 8'hFF;
        v.vis    = 4'b0000;
        v.exp_cyc  = 0;
        v.exp_kill = 4'b0000;
        v.exp_hit  = 1'b0;
        v.exp_tmo  = 4'b0000;
        return v;
    endfunction

    // Frame cost: 1 trigger cycle, 1 per idle slot, 2 (scan+issue) plus the
    // WAIT cycles plus 1 CHECK per answering slot, 2 + TMO per abandoned slot.
    function automatic vec_t model(input vec_t vin);
        vec_t v = vin;
        int   c = 1;
        logic sw, pl;
        v.exp_kill = 4'b0000;
        v.exp_hit  = 1'b0;
        v.exp_tmo  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (!v.active[i]) begin
                c += 1;
            end else if (int'(v.lat[i]) >= TMO) begin
                c += 2 + TMO;
                v.exp_tmo[i] = 1'b1;
            end else begin
                c += 2 + int'(v.lat[i]) + 1 + 1;
                sw = (v.vis == 4'b0001) && (v.sword != 8'hFF) && (v.pos[i] == v.sword);
                pl = (v.player != 8'hFF) && (v.pos[i] == v.player);
                if (sw) v.exp_kill[i] = 1'b1;
                else if (pl) v.exp_hit = 1'b1;
            end
        end
        v.exp_cyc = c;
        return v;
    endfunction

    task automatic apply_inputs(input vec_t v);
        cur            = v;
        slot_active    = v.active;
        slot_pos       = v.pos;
        player_pos     = v.player;
        sword_position = v.sword;
        sword_visible  = v.vis;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        frame_trigger = 1'b0;
        tick();
        tick();
        reset       = 1'b0;
        waiting     = 4'b0000;
        exp_tmo_acc = 4'b0000;
        exp_ovr     = 1'b0;
        prev_hit    = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int inject_at, input string tag);
        int         done_at = 0;
        logic [3:0] kill_or = 4'b0000;
        logic [3:0] upd_or  = 4'b0000;
        int         upd_cnt = 0;
        logic       multi_bad = 1'b0;
        apply_inputs(v);
        if (inject_at > 0) exp_ovr = 1'b1;
        exp_tmo_acc   = exp_tmo_acc | v.exp_tmo;
        frame_trigger = 1'b1;
        cyc = 0;
        while (done_at == 0 && cyc < 400) begin
            tick();
            frame_trigger = 1'b0;
            if (cyc == 1) check({tag, " held_hit"}, 32'(player_hit), 32'(prev_hit));
            if ($countones(slot_update_en) > 1 || $countones(slot_kill) > 1) multi_bad = 1'b1;
            upd_or  = upd_or | slot_update_en;
            upd_cnt += $countones(slot_update_en);
            kill_or = kill_or | slot_kill;
            if (frame_done) done_at = cyc;
            if (cyc == inject_at) frame_trigger = 1'b1;
        end
        check({tag, " frame_done_cycle"}, 32'(done_at), 32'(v.exp_cyc));
        tick();
        frame_trigger = 1'b0;
        check({tag, " done_pulse"}, 32'(frame_done), 32'(0));
        check({tag, " idle_after"}, 32'(busy), 32'(0));
        check({tag, " player_hit"}, 32'(player_hit), 32'(v.exp_hit));
        check({tag, " kills"}, 32'(kill_or), 32'(v.exp_kill));
        check({tag, " kill_idle"}, 32'(slot_kill), 32'(0));
        check({tag, " strobes"}, 32'(upd_or), 32'(v.active));
        check({tag, " strobe_count"}, 32'(upd_cnt), 32'($countones(v.active)));
        check({tag, " onehot"}, 32'(multi_bad), 32'(0));
        check({tag, " timeout_flags"}, 32'(timeout_flags), 32'(exp_tmo_acc));
        check({tag, " overrun"}, 32'(frame_overrun), 32'(exp_ovr));
        prev_hit = v.exp_hit;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   inj;
        int   seen;
        tiles = '{8'h13, 8'h24, 8'hFF, 8'h35};

        // Vectors: expectations worked out by hand from the frame timing rules.
        tbl[0] = blank();                                   // nothing active
        tbl[0].exp_cyc = 5;
        tbl[1] = blank();                                   // slot 2 on player
        tbl[1].active = 4'b0100; tbl[1].pos[2] = 8'h13; tbl[1].player = 8'h13;
        tbl[1].exp_cyc = 8; tbl[1].exp_hit = 1'b1;
        tbl[2] = blank();                                   // slot 1 under sword and player
        tbl[2].active = 4'b0010; tbl[2].pos[1] = 8'h24; tbl[2].sword = 8'h24;
        tbl[2].vis = 4'b0001; tbl[2].player = 8'h24;
        tbl[2].exp_cyc = 8; tbl[2].exp_kill = 4'b0010;
        tbl[3] = blank();                                   // slot 0 never answers
        tbl[3].active = 4'b0001; tbl[3].lat[0] = 8'd255; tbl[3].pos[0] = 8'h55;
        tbl[3].player = 8'h55;
        tbl[3].exp_cyc = 21; tbl[3].exp_tmo = 4'b0001;
        tbl[4] = blank();                                   // all active, latency edges
        tbl[4].active = 4'b1111;
        tbl[4].lat[0] = 8'd2;  tbl[4].lat[1] = 8'd14; tbl[4].lat[2] = 8'd15; tbl[4].lat[3] = 8'd0;
        tbl[4].pos[0] = 8'h13; tbl[4].pos[1] = 8'h24; tbl[4].pos[2] = 8'h13; tbl[4].pos[3] = 8'hFF;
        tbl[4].player = 8'h13; tbl[4].sword = 8'h24; tbl[4].vis = 4'b0001;
        tbl[4].exp_cyc = 46; tbl[4].exp_kill = 4'b0010; tbl[4].exp_hit = 1'b1;
        tbl[4].exp_tmo = 4'b0100;
        tbl[5] = blank();                                   // sword hidden by non-0001 code
        tbl[5].active = 4'b1001; tbl[5].lat[0] = 8'd1; tbl[5].lat[3] = 8'd3;
        tbl[5].pos[0] = 8'h24; tbl[5].pos[3] = 8'h13;
        tbl[5].player = 8'h24; tbl[5].sword = 8'h24; tbl[5].vis = 4'b0011;
        tbl[5].exp_cyc = 15; tbl[5].exp_hit = 1'b1;
        tbl[6] = blank();                                   // FF tiles never match
        tbl[6].active = 4'b1000; tbl[6].player = 8'hFF; tbl[6].vis = 4'b0001;
        tbl[6].exp_cyc = 8;

        apply_inputs(tbl[0]);
        slot_done = 4'b0000;
        waiting   = 4'b0000;
        do_reset();
        check("reset busy", 32'(busy), 32'(0));
        check("reset frame_done", 32'(frame_done), 32'(0));
        check("reset outputs", 32'({slot_update_en, slot_kill, timeout_flags}), 32'(0));
        check("reset flags", 32'({player_hit, frame_overrun}), 32'(0));

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_frame(tbl[i], 0, $sformatf("vec%0d", i));
        end

        // Overrun mid-frame, then a trigger coincident with DONE, then reset clears stickies.
        do_reset();
        run_frame(tbl[4], 10, "ovr_mid");
        run_frame(tbl[1], 8, "ovr_done");
        do_reset();
        check("ovr_reset overrun", 32'(frame_overrun), 32'(0));
        check("ovr_reset timeout_flags", 32'(timeout_flags), 32'(0));
        check("ovr_reset player_hit", 32'(player_hit), 32'(0));

        // Reset asserted while waiting on slot 0.
        apply_inputs(tbl[3]);
        frame_trigger = 1'b1;
        cyc = 0;
        tick();
        frame_trigger = 1'b0;
        tick();
        tick();
        tick();
        check("rst_wait busy_before", 32'(busy), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        waiting = 4'b0000;
        check("rst_wait busy", 32'(busy), 32'(0));
        check("rst_wait outputs", 32'({slot_update_en, slot_kill, timeout_flags, player_hit,
                                      frame_done, frame_overrun}), 32'(0));
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (frame_done || busy) seen++;
        end
        check("rst_wait quiet", 32'(seen), 32'(0));
        prev_hit = 1'b0;

        // Random frames against the model; stickies accumulate without reset.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            v = blank();
            v.active = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) < 3) v.lat[i] = 8'($urandom_range(TMO, TMO + 5));
                else v.lat[i] = 8'($urandom_range(0, TMO - 1));
                v.pos[i] = tiles[$urandom_range(0, 3)];
            end
            v.player = tiles[$urandom_range(0, 3)];
            v.sword  = tiles[$urandom_range(0, 3)];
            case ($urandom_range(0, 3))
                0, 1:    v.vis = 4'b0001;
                2:       v.vis = 4'b0000;
                default: v.vis = 4'b1001;
            endcase
            v = model(v);
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, v.exp_cyc)) : 0;
            run_frame(v, inj, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
